// File: rtl/bit_debounce_if.sv
// Groups the debouncer's level input, counter clear and status outputs.
// Carries no state and adds no latency.
// No handshake: the consumer samples din and clr_cnt on every clock.
interface bit_debounce_if #(
   parameter int CNT_W = 8
);
   logic             din;
   logic             clr_cnt;
   logic             dout;
   logic             rise;
   logic             fall;
   logic [CNT_W-1:0] edge_cnt;
   logic             cnt_sat;

   // Source side: drives the raw level and the counter clear.
   modport master (
      output din, clr_cnt,
      input  dout, rise, fall, edge_cnt, cnt_sat
   );

   // Debouncer side.
   modport slave (
      input  din, clr_cnt,
      output dout, rise, fall, edge_cnt, cnt_sat
   );
endinterface

// File: rtl/bit_debounce.sv
// Single-bit glitch filter: accepts a level after STABLE_CYCLES equal samples, pulses rise/fall, counts edges.
// Latency: a level first sampled at edge k appears on dout/rise/fall after edge k+STABLE_CYCLES-1.
// No backpressure: din is sampled every cycle; at most one accepted edge per STABLE_CYCLES cycles.
module bit_debounce #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input logic          clk,
   input logic          rst,
   bit_debounce_if.slave bus
);
   localparam int            SW   = $clog2(STABLE_CYCLES + 1);
   // stab value on the cycle whose sample completes the stable run
   localparam logic [SW-1:0] LAST = SW'(STABLE_CYCLES - 1);
   localparam logic [SW-1:0] ONE  = SW'(1);

   typedef enum logic [1:0] {
      S_LOW,
      S_PEND_HIGH,
      S_HIGH,
      S_PEND_LOW
   } state_t;

   state_t        state;
   logic [SW-1:0] stab;
   logic          acc_rise;
   logic          acc_fall;
   logic          cnt_full;

   assign cnt_full = &bus.edge_cnt;

   // Decide whether the current sample completes an accepted edge.
   always_comb begin
      acc_rise = 1'b0;
      acc_fall = 1'b0;
      case (state)
         S_LOW:       acc_rise = bus.din  && (LAST == '0);
         S_PEND_HIGH: acc_rise = bus.din  && (stab == LAST);
         S_HIGH:      acc_fall = !bus.din && (LAST == '0);
         S_PEND_LOW:  acc_fall = !bus.din && (stab == LAST);
         default: ;
      endcase
   end

   // Debounce FSM with registered level and edge pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_LOW;
         stab     <= '0;
         bus.dout <= 1'b0;
         bus.rise <= 1'b0;
         bus.fall <= 1'b0;
      end else begin
         bus.rise <= acc_rise;
         bus.fall <= acc_fall;
         case (state)
            S_LOW: begin
               if (bus.din) begin
                  if (acc_rise) begin
                     state    <= S_HIGH;
                     bus.dout <= 1'b1;
                  end else begin
                     state <= S_PEND_HIGH;
                     stab  <= ONE;
                  end
               end
            end
            S_PEND_HIGH: begin
               if (!bus.din) begin
                  state <= S_LOW;
                  stab  <= '0;
               end else if (acc_rise) begin
                  state    <= S_HIGH;
                  bus.dout <= 1'b1;
                  stab     <= '0;
               end else begin
                  stab <= stab + ONE;
               end
            end
            S_HIGH: begin
               if (!bus.din) begin
                  if (acc_fall) begin
                     state    <= S_LOW;
                     bus.dout <= 1'b0;
                  end else begin
                     state <= S_PEND_LOW;
                     stab  <= ONE;
                  end
               end
            end
            S_PEND_LOW: begin
               if (bus.din) begin
                  state <= S_HIGH;
                  stab  <= '0;
               end else if (acc_fall) begin
                  state    <= S_LOW;
                  bus.dout <= 1'b0;
                  stab     <= '0;
               end else begin
                  stab <= stab + ONE;
               end
            end
            default: begin
               state <= S_LOW;
               stab  <= '0;
            end
         endcase
      end
   end

   // Saturating edge counter; a same-cycle clear beats the increment.
   always_ff @(posedge clk) begin
      if (rst || bus.clr_cnt) begin
         bus.edge_cnt <= '0;
         bus.cnt_sat  <= 1'b0;
      end else if ((acc_rise || acc_fall) && !cnt_full) begin
         bus.edge_cnt <= bus.edge_cnt + 1'b1;
         bus.cnt_sat  <= (bus.edge_cnt == {{(CNT_W-1){1'b1}}, 1'b0});
      end
   end
endmodule

// File: tb/tb_bit_debounce.sv
// Bench for bit_debounce: two instances (4-sample/2-bit counter and 1-sample/8-bit counter)
// share one directed stimulus; a sample-history model is compared every cycle, and
// hand-computed expectations pin the 4-sample instance and the model at key points.
module tb_bit_debounce;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic din = 1'b0;
   logic clr_cnt = 1'b0;
   int   errors = 0;
   int   checks = 0;
   bit   chk_on = 1'b0;

   always #5 clk = ~clk;

   bit_debounce_if #(.CNT_W(2)) b4 ();
   bit_debounce_if #(.CNT_W(8)) b1 ();
   assign b4.din = din;
   assign b4.clr_cnt = clr_cnt;
   assign b1.din = din;
   assign b1.clr_cnt = clr_cnt;

   bit_debounce #(.STABLE_CYCLES(4), .CNT_W(2)) u4 (.clk(clk), .rst(rst), .bus(b4));
   bit_debounce #(.STABLE_CYCLES(1), .CNT_W(8)) u1 (.clk(clk), .rst(rst), .bus(b1));

   // Model: a level is accepted when the last N samples since reset all differ from dout.
   int       ns   [2] = '{4, 1};
   int       mx   [2] = '{3, 255};
   logic [7:0] hist [2] = '{8'd0, 8'd0};
   int       nval [2] = '{0, 0};
   bit       mdout[2] = '{0, 0};
   bit       mrise[2] = '{0, 0};
   bit       mfall[2] = '{0, 0};
   int       mcnt [2] = '{0, 0};
   bit       msat [2] = '{0, 0};

   always @(posedge clk) begin : model
      bit acc;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            hist[k] = 8'd0; nval[k] = 0; mdout[k] = 0;
            mrise[k] = 0; mfall[k] = 0; mcnt[k] = 0; msat[k] = 0;
         end else begin
            hist[k] = {hist[k][6:0], din};
            if (nval[k] < ns[k]) nval[k]++;
            acc = (nval[k] >= ns[k]);
            for (int j = 0; j < ns[k]; j++)
               if (hist[k][j] == mdout[k]) acc = 0;
            mrise[k] = acc && !mdout[k];
            mfall[k] = acc && mdout[k];
            if (acc) mdout[k] = !mdout[k];
            if (clr_cnt) mcnt[k] = 0;
            else if (acc && mcnt[k] < mx[k]) mcnt[k]++;
            msat[k] = (mcnt[k] == mx[k]);
         end
      end
   end

   task automatic cmp(input string name, input int got, input int want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
      end
   endtask

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         cmp("m4.dout", int'(b4.dout), int'(mdout[0]));
         cmp("m4.rise", int'(b4.rise), int'(mrise[0]));
         cmp("m4.fall", int'(b4.fall), int'(mfall[0]));
         cmp("m4.cnt",  int'(b4.edge_cnt), mcnt[0]);
         cmp("m4.sat",  int'(b4.cnt_sat), int'(msat[0]));
         cmp("m1.dout", int'(b1.dout), int'(mdout[1]));
         cmp("m1.rise", int'(b1.rise), int'(mrise[1]));
         cmp("m1.fall", int'(b1.fall), int'(mfall[1]));
         cmp("m1.cnt",  int'(b1.edge_cnt), mcnt[1]);
         cmp("m1.sat",  int'(b1.cnt_sat), int'(msat[1]));
      end
   end

   // Literal expectation on the 4-sample instance and on the model.
   task automatic expect4(input string name, input int d, input int r, input int f,
                          input int c, input int s);
      cmp({name, ".dout"}, int'(b4.dout), d);
      cmp({name, ".rise"}, int'(b4.rise), r);
      cmp({name, ".fall"}, int'(b4.fall), f);
      cmp({name, ".cnt"},  int'(b4.edge_cnt), c);
      cmp({name, ".sat"},  int'(b4.cnt_sat), s);
      cmp({name, ".mdl"},  mcnt[0] * 8 + int'(mdout[0]) * 4 + int'(mrise[0]) * 2 + int'(mfall[0]),
          c * 8 + d * 4 + r * 2 + f);
   endtask

   // Apply one sample (driven on the falling edge), return after the next rising edge.
   task automatic step(input bit d, input bit c);
      din = d;
      clr_cnt = c;
      @(negedge clk);
   endtask

   int exp_cnt[5] = '{1, 2, 3, 3, 3};

   initial begin
      @(negedge clk);
      // Reset held 3 cycles with din high.
      rst = 1'b1;
      for (int i = 0; i < 3; i++) step(1, 0);
      chk_on = 1'b1;
      expect4("reset", 0, 0, 0, 0, 0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) step(1, 0);
      expect4("post_rst3", 0, 0, 0, 0, 0);
      step(1, 0);
      expect4("post_rst4", 1, 1, 0, 1, 0);
      step(1, 0);
      expect4("rise_drop", 1, 0, 0, 1, 0);

      // Fall after 4 low samples.
      for (int i = 0; i < 3; i++) step(0, 0);
      expect4("low3", 1, 0, 0, 1, 0);
      step(0, 0);
      expect4("fall", 0, 0, 1, 2, 0);
      step(0, 0);
      expect4("fall_drop", 0, 0, 0, 2, 0);

      // Three-sample glitch rejected.
      for (int i = 0; i < 3; i++) step(1, 0);
      step(0, 0);
      expect4("glitch", 0, 0, 0, 2, 0);
      step(0, 0);

      // Clear in the cycle a rise is accepted.
      for (int i = 0; i < 3; i++) step(1, 0);
      step(1, 1);
      expect4("clr_coll", 1, 1, 0, 0, 0);
      step(1, 0);

      // Five edges into the 2-bit counter.
      for (int e = 0; e < 5; e++) begin
         bit lvl;
         lvl = (e % 2 == 1);
         for (int i = 0; i < 3; i++) step(lvl, 0);
         step(lvl, 0);
         expect4($sformatf("sat%0d", e), int'(lvl), int'(lvl), int'(!lvl),
                 exp_cnt[e], int'(e >= 2));
      end
      step(0, 1);
      expect4("clr", 0, 0, 0, 0, 0);

      // Reset in the middle of a pending high.
      step(1, 0);
      step(1, 0);
      rst = 1'b1;
      step(1, 0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) step(1, 0);
      expect4("midrst3", 0, 0, 0, 0, 0);
      step(1, 0);
      expect4("midrst4", 1, 1, 0, 1, 0);
      step(1, 0);

      chk_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
